// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one unified memory port between an instruction-fetch port (I) and a
// data load/store port (D). One transaction is in flight at a time. A request
// is granted only from IDLE. The granted address/we/wdata are latched and held
// on the memory port until m_ready or a timeout. The granted port then
// receives a one-cycle ack in DONE.
//
// Configuration macro: MEM_ARBITER_RR_EN
//   undefined : fixed priority, D wins over I when both request.
//   defined   : round robin on conflict. The port not granted last wins, and
//               the last grant resets to I so that D wins the first conflict.
//
// Parameters
//   AW      address width
//   DW      data width
//   TIMEOUT wait cycles on m_ready before the transaction is aborted (1..255)
//
// Ports
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   i_req    fetch request, held until i_ack
//   i_addr   fetch address
//   i_rdata  fetched word, valid with i_ack
//   i_ack    one-cycle fetch completion
//   d_req    data request, held until d_ack
//   d_we     1 = store, 0 = load
//   d_addr   data address
//   d_wdata  store data
//   d_rdata  load data, valid with d_ack
//   d_ack    one-cycle data completion
//   m_req    memory request
//   m_we     memory write enable
//   m_addr   memory address
//   m_wdata  memory write data
//   m_rdata  memory read data, valid with m_ready
//   m_ready  memory completion, only looked at while m_req = 1
//   stall    high while any request is still waiting for its ack
//   err      sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          stall,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter runs 0 .. TIMEOUT-1. The busy cycle that sees it at
    // TIMEOUT-1 without m_ready is the last one allowed, so an unanswered
    // transaction occupies exactly TIMEOUT busy cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [7:0]    wait_q, wait_d;
    // Port owning the current or most recent transaction (1 = D). It steers
    // the ack and the read-data capture. Under round robin it also serves as
    // the last-grant record.
    logic          gnt_d_q, gnt_d_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic          pick_d;

    // Arbitration decision, only consumed in IDLE.
    always_comb begin
        pick_d = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        if (d_req && i_req) begin
            pick_d = ~gnt_d_q;
        end else begin
            pick_d = d_req;
        end
`else
        pick_d = d_req;
`endif
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        gnt_d_d   = gnt_d_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (d_req || i_req) begin
                    gnt_d_d = pick_d;
                    if (pick_d) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        state_d = DBUSY;
                    end else begin
                        // Fetches never write, and they carry no write data.
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        state_d = IBUSY;
                    end
                end
            end

            IBUSY, DBUSY: begin
                if (m_ready) begin
                    // Stores return nothing, so d_rdata keeps its old value.
                    if (!we_q) begin
                        if (gnt_d_q) begin
                            d_rdata_d = m_rdata;
                        end else begin
                            i_rdata_d = m_rdata;
                        end
                    end
                    state_d = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    // Abort: the requester still gets its ack, with zero read
                    // data. A timed-out store leaves d_rdata unchanged.
                    err_d = 1'b1;
                    if (!we_q) begin
                        if (gnt_d_q) begin
                            d_rdata_d = '0;
                        end else begin
                            i_rdata_d = '0;
                        end
                    end
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            DONE: begin
                wait_d  = '0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wait_q    <= '0;
            gnt_d_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            gnt_d_q   <= gnt_d_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    // The memory port is decoded straight from the state register. An
    // asynchronous reset therefore drops m_req in the same cycle.
    assign m_req   = (state_q == IBUSY) || (state_q == DBUSY);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    // Only one port owns DONE, so the two acks are mutually exclusive.
    assign i_ack   = (state_q == DONE) && !gnt_d_q;
    assign d_ack   = (state_q == DONE) && gnt_d_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

    assign stall   = (i_req && !i_ack) || (d_req && !d_ack);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter TIMEOUT, 255, max cycles waiting on m_ready before abort (1..255).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction-fetch request; held until i_ack.
REQ-007 i_addr  in  AW  fetch address.
REQ-008 i_rdata  out  DW  fetched word; valid when i_ack=1.
REQ-009 i_ack  out  1  one-cycle completion pulse for fetch.
REQ-010 d_req  in  1  data load/store request; held until d_ack.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_addr  in  AW  data address.
REQ-013 d_wdata  in  DW  store data.
REQ-014 d_rdata  out  DW  load data; valid when d_ack=1.
REQ-015 d_ack  out  1  one-cycle completion pulse for data.
REQ-016 m_req  out  1  request to the unified memory.
REQ-017 m_we  out  1  memory write enable.
REQ-018 m_addr  out  AW  memory address.
REQ-019 m_wdata  out  DW  memory write data.
REQ-020 m_rdata  in  DW  memory read data; valid with m_ready.
REQ-021 m_ready  in  1  memory completion; sampled only while m_req=1.
REQ-022 stall  out  1  high while any request is not yet acknowledged.
REQ-023 err  out  1  sticky timeout flag.

Function
REQ-024 FSM states IDLE, IBUSY, DBUSY, DONE; one transaction in flight at a time.
REQ-025 IDLE: if a request is granted, latch address, we (0 for fetch), wdata into registers and go to IBUSY or DBUSY; m_req, m_we, m_addr, m_wdata driven from these registers.
REQ-026 Fixed priority: d_req wins over i_req when both high in IDLE.
REQ-027 IBUSY/DBUSY: m_req=1 and m_addr/m_we/m_wdata held stable until m_ready=1; wait counter increments each cycle.
REQ-028 On m_ready=1: capture m_rdata into the granted port's rdata register (stores capture nothing; d_rdata unchanged), go to DONE.
REQ-029 DONE: granted port's ack=1 for exactly this cycle, m_req=0, no new grant; next state IDLE.
REQ-030 Minimum latency: req sampled at edge 0, m_req high cycle 1, m_ready in cycle 1 -> ack high cycle 2; back-to-back grant earliest cycle 3.
REQ-031 Requests are sampled only in IDLE; a req deasserted before grant is dropped without ack.
REQ-032 Timeout: if wait counter reaches TIMEOUT without m_ready, set err, force rdata to 0, go to DONE and ack normally.
REQ-033 stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
REQ-034 i_ack and d_ack are never high in the same cycle.

Reset
REQ-035 reset=0 forces state IDLE, m_req/m_we/i_ack/d_ack/err=0, m_addr/m_wdata/i_rdata/d_rdata=0, wait counter 0, last-grant=I, asynchronously.
REQ-036 Reset mid-transaction aborts it with no ack; m_req drops immediately.
REQ-037 err clears only on reset.

Configuration
REQ-038 Macro MEM_ARBITER_RR_EN defined: when both request in IDLE, grant the port not granted last (last-grant register, reset to I so D wins first); single requester always granted.
REQ-039 Macro undefined: fixed D-over-I priority per REQ-026; no last-grant register.

Verification
REQ-040 Fetch only, i_addr=0x100, m_ready in first m_req cycle, m_rdata=0x2402000A -> i_ack at cycle 2, i_rdata=0x2402000A, m_we=0.
REQ-041 i_req and d_req (load 0x200) together -> d_ack first; i_ack at earliest cycle 5 with m_ready held high (both macro settings, first conflict).
REQ-042 Store d_addr=0x44, d_wdata=0xDEADBEEF, m_ready after 3 wait cycles -> m_we=1, m_addr/m_wdata stable all 3 cycles, d_ack once, d_rdata unchanged.
REQ-043 m_ready never asserted, TIMEOUT=255 -> ack after 255 wait cycles, rdata=0, err=1 and stays 1 until reset.
REQ-044 With MEM_ARBITER_RR_EN, both ports requesting continuously -> grants alternate D,I,D,I; without macro -> D every transaction.
REQ-045 reset asserted while DBUSY -> m_req=0 same cycle, no d_ack, state IDLE after release.
